// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match, RX/TX FIFO handshakes.
// Optional feature macro CLK_STRETCH_EN: hold SCL low while the TX FIFO is empty during a read.
module i2c_target #(
    parameter int I2C_DATA_WIDTH = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_oe,
    output logic                      sda_oe,
    input  logic [I2C_ADDR_WIDTH-1:0] slv_addr,
    input  logic                      rx_full,
    output logic                      rx_wr_en,
    output logic [I2C_DATA_WIDTH-1:0] rx_wr_data,
    input  logic                      tx_empty,
    output logic                      tx_rd_en,
    input  logic [I2C_DATA_WIDTH-1:0] tx_rd_data,
    output logic                      busy,
    output logic                      rx_overflow
);

    localparam int         DW       = I2C_DATA_WIDTH;
    localparam logic [3:0] LAST_BIT = 4'(DW - 1);
    localparam logic [3:0] ACK_SLOT = 4'(DW);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  scl_sync;
    logic [SYNC_STAGES-1:0]  sda_sync;
    logic                    scl_s;
    logic                    sda_s;
    logic                    scl_d;
    logic                    sda_d;
    logic                    scl_rise;
    logic                    scl_fall;
    logic                    start_det;
    logic                    stop_det;
    logic [DW-1:0]           shift;
    logic [DW-1:0]           shift_nxt;
    logic [3:0]              bit_cnt;
    logic                    addr_hit;
    logic                    rw;
    logic                    ack_ok;
    logic                    ack_phase;
    logic [1:0]              tx_step;

    // Synchroniser plus one edge-detect flop; idles high like a released bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s && !scl_d;
    assign scl_fall  = !scl_s && scl_d;
    assign start_det = scl_s && scl_d && sda_d && !sda_s;
    assign stop_det  = scl_s && scl_d && !sda_d && sda_s;
    assign shift_nxt = {shift[DW-2:0], sda_s};
    assign addr_hit  = (shift_nxt[DW-1 -: I2C_ADDR_WIDTH] == slv_addr);

`ifdef CLK_STRETCH_EN
    logic scl_hold;
    assign scl_oe = scl_hold;
`else
    assign scl_oe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            ack_ok      <= 1'b0;
            ack_phase   <= 1'b0;
            tx_step     <= '0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            rx_wr_en    <= 1'b0;
            rx_wr_data  <= '0;
            tx_rd_en    <= 1'b0;
            rx_overflow <= 1'b0;
`ifdef CLK_STRETCH_EN
            scl_hold    <= 1'b0;
`endif
        end else begin
            rx_wr_en    <= 1'b0;
            tx_rd_en    <= 1'b0;
            rx_overflow <= 1'b0;
            if (start_det || stop_det) begin
                // A repeated START keeps busy; only STOP or an address miss ends the transaction.
                state     <= start_det ? ADDR : IDLE;
                shift     <= '0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                tx_step   <= '0;
                sda_oe    <= 1'b0;
                if (stop_det)
                    busy <= 1'b0;
`ifdef CLK_STRETCH_EN
                scl_hold  <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_nxt;
                            if (bit_cnt == LAST_BIT) begin
                                if (addr_hit) begin
                                    rw      <= sda_s;
                                    busy    <= 1'b1;
                                    bit_cnt <= ACK_SLOT;
                                    state   <= ADDR_ACK;
                                end else begin
                                    busy    <= 1'b0;
                                    bit_cnt <= '0;
                                    state   <= IDLE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // First fall drives the ACK/NACK bit, second fall releases it.
                    ADDR_ACK, RX_ACK: begin
                        if (scl_rise)
                            bit_cnt <= '0;
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_oe    <= (state == ADDR_ACK) || ack_ok;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_oe    <= 1'b0;
                                bit_cnt   <= '0;
                                if (state == ADDR_ACK)
                                    state <= rw ? TX_LOAD : RX_BYTE;
                                else
                                    state <= ack_ok ? RX_BYTE : IDLE;
                            end
                        end
                    end

                    RX_BYTE: begin
                        if (scl_rise) begin
                            shift <= shift_nxt;
                            if (bit_cnt == LAST_BIT) begin
                                if (!rx_full) begin
                                    rx_wr_en   <= 1'b1;
                                    rx_wr_data <= shift_nxt;
                                    ack_ok     <= 1'b1;
                                end else begin
                                    rx_overflow <= 1'b1;
                                    ack_ok      <= 1'b0;
                                end
                                bit_cnt <= ACK_SLOT;
                                state   <= RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // Pop, wait one clk for the FIFO output register, then load.
                    TX_LOAD: begin
                        case (tx_step)
                            2'd0: begin
                                if (!tx_empty) begin
                                    tx_rd_en <= 1'b1;
                                    tx_step  <= 2'd1;
                                end else begin
`ifdef CLK_STRETCH_EN
                                    scl_hold <= 1'b1;
`else
                                    shift    <= '1;
                                    sda_oe   <= 1'b0;
                                    bit_cnt  <= '0;
                                    state    <= TX_BYTE;
`endif
                                end
                            end
                            2'd1: tx_step <= 2'd2;
                            default: begin
                                shift   <= tx_rd_data;
                                sda_oe  <= ~tx_rd_data[DW-1];
                                bit_cnt <= '0;
                                tx_step <= 2'd0;
                                state   <= TX_BYTE;
                            end
                        endcase
                    end

                    TX_BYTE: begin
`ifdef CLK_STRETCH_EN
                        scl_hold <= 1'b0;
`endif
                        if (scl_rise)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == ACK_SLOT) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                shift  <= {shift[DW-2:0], 1'b1};
                                sda_oe <= ~shift[DW-2];
                            end
                        end
                    end

                    // bit_cnt is ACK_SLOT on entry and 0 once the ACK has been sampled.
                    TX_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (sda_s)
                                state <= IDLE;
                        end else if (scl_fall && bit_cnt == 4'd0) begin
                            state <= TX_LOAD;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus master model, FIFO models, transaction-level reference and scoreboard.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_oe, sda_oe, rx_wr_en, tx_rd_en, busy, rx_overflow;
    logic [6:0] slv_addr = 7'h50;
    logic       rx_full = 1'b0;
    logic [7:0] rx_wr_data;
    logic       tx_empty = 1'b1;
    logic [7:0] tx_rd_data = 8'h00;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .reset(reset), .scl_i(scl_line), .sda_i(sda_line),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .slv_addr(slv_addr),
        .rx_full(rx_full), .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data),
        .tx_empty(tx_empty), .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data),
        .busy(busy), .rx_overflow(rx_overflow)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_fifo[$];
    logic [7:0] model_tx[$];
    int         pop_cnt = 0;
    int         ovf_cnt = 0;
    int         sda_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard for RX writes, pulse counters for the other strobes.
    always @(negedge clk) begin
        if (rx_wr_en) begin
            if (exp_rx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: actual write 0x%0h, required no write", rx_wr_data);
            end else begin
                check("rx_data", rx_wr_data, exp_rx.pop_front());
            end
        end
        if (tx_rd_en)    pop_cnt++;
        if (rx_overflow) ovf_cnt++;
        if (sda_oe)      sda_cnt++;
`ifndef CLK_STRETCH_EN
        if (scl_oe) check("scl_oe_tied_low", scl_oe, 1'b0);
`endif
    end

    // TX FIFO: registered output, data valid the clk after the read strobe.
    always @(posedge clk) begin
        if (tx_rd_en && tx_fifo.size() > 0)
            tx_rd_data <= tx_fifo.pop_front();
        tx_empty <= (tx_fifo.size() == 0);
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: actual still running, required finish within 90000 clks");
        $fatal(1, "watchdog");
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_high();
        int t = 0;
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (scl_line !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL scl_release: actual SCL held low, required release within 5000 clks");
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_high();   qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_high();   qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;    qwait();
        scl_high();   qwait();
        r = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(nack, r);
    endtask

    // Write transaction: ACK only while the address matched and nothing has been refused yet.
    task automatic do_write(input logic [6:0] own, input logic [6:0] addr, input int n,
                            input logic [7:0] d [4], input bit f [4]);
        logic ack;
        bit   accepting;
        int   exp_ovf = 0;
        int   ovf_base = ovf_cnt;
        int   sda_base = sda_cnt;
        slv_addr = own;
        bus_start();
        wr_byte({addr, 1'b0}, ack);
        accepting = (addr == own);
        check("wr_addr_ack", ack, accepting);
        check("wr_busy", busy, accepting);
        for (int i = 0; i < n; i++) begin
            rx_full = f[i];
            if (accepting && !f[i]) exp_rx.push_back(d[i]);
            if (accepting && f[i])  exp_ovf++;
            wr_byte(d[i], ack);
            check("wr_data_ack", ack, accepting && !f[i]);
            if (f[i]) accepting = 1'b0;
        end
        rx_full = 1'b0;
        bus_stop();
        check("wr_busy_after_stop", busy, 1'b0);
        check("wr_overflow_count", ovf_cnt - ovf_base, exp_ovf);
        if (addr != own) check("wr_miss_no_drive", sda_cnt - sda_base, 0);
    endtask

    // Read transaction: each byte comes from the FIFO in order, or 0xFF when empty or not addressed.
    task automatic do_read(input logic [6:0] own, input logic [6:0] addr, input int n,
                           input logic [7:0] v [4], input int k);
        logic       ack;
        logic [7:0] d, exp;
        bit         match;
        int         exp_pops = 0;
        int         pop_base;
        tx_fifo.delete();
        model_tx.delete();
        for (int i = 0; i < k; i++) begin
            tx_fifo.push_back(v[i]);
            model_tx.push_back(v[i]);
        end
        qwait();
        pop_base = pop_cnt;
        slv_addr = own;
        match = (addr == own);
        bus_start();
        wr_byte({addr, 1'b1}, ack);
        check("rd_addr_ack", ack, match);
        check("rd_busy", busy, match);
        for (int i = 0; i < n; i++) begin
            exp = 8'hFF;
            if (match && model_tx.size() > 0) begin
                exp = model_tx.pop_front();
                exp_pops++;
            end
            rd_byte(i == n - 1, d);
            check("rd_data", d, exp);
        end
        bus_stop();
        check("rd_busy_after_stop", busy, 1'b0);
        check("rd_pop_count", pop_cnt - pop_base, exp_pops);
    endtask

    initial begin
        logic [7:0] d [4];
        bit         f [4];
        logic [7:0] v [4];
        logic [7:0] rb;
        logic [7:0] pat;
        logic       ack, r;
        int         base;

        repeat (5) @(negedge clk);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_scl_oe", scl_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx_wr_en", rx_wr_en, 1'b0);
        check("reset_rx_wr_data", rx_wr_data, 8'h00);
        check("reset_tx_rd_en", tx_rd_en, 1'b0);
        check("reset_rx_overflow", rx_overflow, 1'b0);
        reset = 1'b0;
        qwait();

        // Two-byte write, address mismatch, overflow on the second byte.
        d = '{8'h12, 8'h34, 8'h00, 8'h00};
        f = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_write(7'h50, 7'h50, 2, d, f);
        do_write(7'h50, 7'h51, 1, d, f);
        d = '{8'h11, 8'h22, 8'h00, 8'h00};
        f = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_write(7'h50, 7'h50, 2, d, f);

        // Two-byte read, master NACKs the second.
        v = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        do_read(7'h50, 7'h50, 2, v, 2);

        // Write 0x07, repeated START, read 0x99.
        tx_fifo.delete();
        tx_fifo.push_back(8'h99);
        base = pop_cnt;
        slv_addr = 7'h50;
        bus_start();
        wr_byte(8'hA0, ack);
        check("sr_addr_ack", ack, 1'b1);
        exp_rx.push_back(8'h07);
        wr_byte(8'h07, ack);
        check("sr_data_ack", ack, 1'b1);
        bus_start();
        check("sr_busy_held", busy, 1'b1);
        wr_byte(8'hA1, ack);
        check("sr_read_addr_ack", ack, 1'b1);
        rd_byte(1'b1, rb);
        check("sr_read_data", rb, 8'h99);
        bus_stop();
        check("sr_pop_count", pop_cnt - base, 1);
        check("sr_busy_after_stop", busy, 1'b0);

        // Reset while the address ACK is on the bus.
        bus_start();
        pat = 8'hA0;
        for (int i = 7; i >= 0; i--) bit_x(pat[i], r);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        check("ack_before_reset", sda_oe, 1'b1);
        check("busy_before_reset", busy, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("reset_drops_sda_oe", sda_oe, 1'b0);
        check("reset_drops_busy", busy, 1'b0);
        reset = 1'b0;
        qwait();
        scl_m = 1'b0; qwait();
        bus_stop();

        // Reset during bit 4 of a data byte: nothing may reach the RX FIFO.
        bus_start();
        wr_byte(8'hA0, ack);
        check("midbyte_addr_ack", ack, 1'b1);
        pat = 8'h5A;
        for (int i = 7; i >= 4; i--) bit_x(pat[i], r);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("midbyte_sda_oe", sda_oe, 1'b0);
        reset = 1'b0;
        bus_stop();
        d = '{8'hE7, 8'h00, 8'h00, 8'h00};
        f = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_write(7'h50, 7'h50, 1, d, f);

`ifdef CLK_STRETCH_EN
        // Read with an empty TX FIFO: SCL held until 0x3C arrives.
        tx_fifo.delete();
        qwait();
        bus_start();
        wr_byte(8'hA1, ack);
        check("stretch_addr_ack", ack, 1'b1);
        fork
            begin
                repeat (100) @(negedge clk);
                check("stretch_scl_oe_held", scl_oe, 1'b1);
                tx_fifo.push_back(8'h3C);
            end
            rd_byte(1'b1, rb);
        join
        check("stretch_data", rb, 8'h3C);
        check("stretch_scl_oe_released", scl_oe, 1'b0);
        bus_stop();
`endif

        // Randomised transactions against the transaction-level model.
        for (int t = 0; t < 20; t++) begin
            logic [6:0] own, addr, mask;
            int         n, k;
            own  = 7'($urandom_range(0, 127));
            mask = 7'd1 << $urandom_range(0, 6);
            addr = ($urandom_range(0, 9) < 7) ? own : (own ^ mask);
            n    = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                d[i] = 8'($urandom);
                v[i] = 8'($urandom);
                f[i] = ($urandom_range(0, 4) == 0);
            end
`ifdef CLK_STRETCH_EN
            k = n;
`else
            k = $urandom_range(0, n);
`endif
            if ($urandom_range(0, 1) == 0)
                do_write(own, addr, n, d, f);
            else
                do_read(own, addr, n, v, k);
        end

        qwait();
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
